// File: rtl/apv_pkg.sv
// ---------------------------------------------------------------------------
// apv_pkg
// Shared types and constants for the APV25 frame decoder slice.
//   apv_state_e    : decoder FSM states (idle, header, address, error, data)
//   APV_FRAME_LEN  : analog samples per frame (one per strip)
//   APV_ADDR_BITS  : pipeline address width, transmitted MSB first
//   APV_HDR_LEN    : number of consecutive digital-one samples in a header
// ---------------------------------------------------------------------------
package apv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_ADDR,
    ST_ERRB,
    ST_DATA
  } apv_state_e;

  localparam int APV_FRAME_LEN = 128;
  localparam int APV_ADDR_BITS = 8;
  localparam int APV_HDR_LEN   = 3;

endpackage

// File: rtl/apv_sync_monitor.sv
// ---------------------------------------------------------------------------
// apv_sync_monitor
// Watches the spacing between APV sync pulses and reports lock when two
// consecutive spacings equal SYNC_PERIOD valid samples.
// Ports:
//   i_clk        : clock, rising edge
//   i_rstb       : asynchronous active-low reset
//   i_valid      : qualifies the current sample; nothing moves without it
//   i_syncPulse  : the current valid sample completed a sync pulse
//                  (single high sample followed by a low one)
//   i_header     : the current valid sample completed a frame header
//   o_synced     : sync-pulse train locked
// ---------------------------------------------------------------------------
module apv_sync_monitor #(
  parameter int SYNC_PERIOD = 35
) (
  input  logic i_clk,
  input  logic i_rstb,
  input  logic i_valid,
  input  logic i_syncPulse,
  input  logic i_header,
  output logic o_synced
);

  localparam logic [5:0] SPACE_SAT = 6'd63;

  logic [5:0] r_spaceCnt;
  logic       r_armed;
  logic       r_prevMatch;
  logic       r_synced;
  logic       w_match;

  // The pulse is recognised on the low sample after its high sample, so the
  // counter restarts on that low sample and the high-to-high spacing is the
  // count plus one. A saturated counter can never be a match.
  assign w_match = (r_spaceCnt != SPACE_SAT) &&
                   (({1'b0, r_spaceCnt} + 7'd1) == 7'(SYNC_PERIOD));

  // A header disarms the counter for the whole frame; the first sync pulse
  // afterwards only re-arms it, and the chain of consecutive matches restarts.
  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      r_spaceCnt  <= '0;
      r_armed     <= 1'b0;
      r_prevMatch <= 1'b0;
      r_synced    <= 1'b0;
    end else if (i_valid) begin
      if (i_header) begin
        r_armed <= 1'b0;
      end else if (i_syncPulse) begin
        r_spaceCnt <= '0;
        r_armed    <= 1'b1;
        if (!r_armed) begin
          r_prevMatch <= 1'b0;
        end else if (w_match) begin
          r_prevMatch <= 1'b1;
          if (r_prevMatch) begin
            r_synced <= 1'b1;
          end
        end else begin
          r_prevMatch <= 1'b0;
          r_synced    <= 1'b0;
        end
      end else if (r_armed && (r_spaceCnt != SPACE_SAT)) begin
        r_spaceCnt <= r_spaceCnt + 6'd1;
      end
    end
  end

  assign o_synced = r_synced;

endmodule

// File: rtl/apv_frame_decoder.sv
// ---------------------------------------------------------------------------
// apv_frame_decoder
// Decodes the digital frame structure of one APV25 channel: a 3-sample
// header, 8 address bits (MSB first), one error bit and 128 analog samples.
// Optional sync-pulse lock monitor is compiled in with `define APV_SYNC_MON_EN;
// without it SYNCED is tied low.
// Ports:
//   CLK          : clock, rising edge
//   RSTb         : asynchronous active-low reset
//   SAMPLE       : 12-bit ADC word
//   SAMPLE_VALID : qualifies SAMPLE; invalid cycles freeze all state
//   DATA         : analog payload of the current strip
//   DATA_VALID   : one-cycle strobe for DATA/CH_INDEX
//   CH_INDEX     : strip index 0..127
//   FRAME_DONE   : one-cycle pulse with the last strip of a frame
//   ADDR         : pipeline address of the last complete frame
//   ERR_BIT      : error bit of the last complete frame
//   FRAME_CNT    : completed frame count, wraps
//   SYNCED       : sync-pulse train locked
// ---------------------------------------------------------------------------
module apv_frame_decoder
  import apv_pkg::*;
#(
  parameter logic [11:0] THRESHOLD   = 12'h680,
  parameter int          SYNC_PERIOD = 35
) (
  input  logic        CLK,
  input  logic        RSTb,
  input  logic [11:0] SAMPLE,
  input  logic        SAMPLE_VALID,
  output logic [11:0] DATA,
  output logic        DATA_VALID,
  output logic [6:0]  CH_INDEX,
  output logic        FRAME_DONE,
  output logic [7:0]  ADDR,
  output logic        ERR_BIT,
  output logic [15:0] FRAME_CNT,
  output logic        SYNCED
);

  localparam logic [1:0] HDR_LAST  = 2'(APV_HDR_LEN - 1);
  localparam logic [6:0] ADDR_LAST = 7'(APV_ADDR_BITS - 1);
  localparam logic [6:0] IDX_LAST  = 7'(APV_FRAME_LEN - 1);

  apv_state_e  r_state;
  apv_state_e  w_stateNext;
  logic [1:0]  r_run;
  logic [1:0]  w_runNext;
  logic [6:0]  r_idx;
  logic [6:0]  w_idxNext;
  logic [7:0]  r_addrShift;
  logic [7:0]  w_addrShiftNext;
  logic        r_errShadow;
  logic        w_errShadowNext;
  logic        w_high;
  logic        w_dataEvt;
  logic        w_lastEvt;

  logic [11:0] r_data;
  logic        r_dataValid;
  logic [6:0]  r_chIndex;
  logic        r_frameDone;
  logic [7:0]  r_addr;
  logic        r_err;
  logic [15:0] r_frameCnt;

  assign w_high = (SAMPLE > THRESHOLD);

  // r_idx counts address bits in ST_ADDR and strips in ST_DATA. Address and
  // error bits go to shadow registers so a partial frame never disturbs the
  // published ADDR/ERR_BIT.
  always_comb begin
    w_stateNext     = r_state;
    w_runNext       = r_run;
    w_idxNext       = r_idx;
    w_addrShiftNext = r_addrShift;
    w_errShadowNext = r_errShadow;
    w_dataEvt       = 1'b0;
    w_lastEvt       = 1'b0;
    if (SAMPLE_VALID) begin
      case (r_state)
        ST_IDLE: begin
          if (w_high) begin
            w_stateNext = ST_HDR;
            w_runNext   = 2'd1;
          end
        end
        ST_HDR: begin
          if (w_high) begin
            w_runNext = r_run + 2'd1;
            if (r_run == HDR_LAST) begin
              w_stateNext = ST_ADDR;
              w_idxNext   = '0;
            end
          end else begin
            // run=1 is a sync pulse, run=2 a glitch; both just drop back
            w_stateNext = ST_IDLE;
            w_runNext   = '0;
          end
        end
        ST_ADDR: begin
          w_addrShiftNext = {r_addrShift[6:0], w_high};
          if (r_idx == ADDR_LAST) begin
            w_stateNext = ST_ERRB;
            w_idxNext   = '0;
          end else begin
            w_idxNext = r_idx + 7'd1;
          end
        end
        ST_ERRB: begin
          w_errShadowNext = w_high;
          w_stateNext     = ST_DATA;
          w_idxNext       = '0;
        end
        ST_DATA: begin
          w_dataEvt = 1'b1;
          if (r_idx == IDX_LAST) begin
            w_lastEvt   = 1'b1;
            w_stateNext = ST_IDLE;
            w_runNext   = '0;
            w_idxNext   = '0;
          end else begin
            w_idxNext = r_idx + 7'd1;
          end
        end
        default: begin
          w_stateNext = ST_IDLE;
          w_runNext   = '0;
          w_idxNext   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      r_state     <= ST_IDLE;
      r_run       <= '0;
      r_idx       <= '0;
      r_addrShift <= '0;
      r_errShadow <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_run       <= w_runNext;
      r_idx       <= w_idxNext;
      r_addrShift <= w_addrShiftNext;
      r_errShadow <= w_errShadowNext;
    end
  end

  // Registered outputs: strobes fall on any cycle without a data sample,
  // payload and frame results hold until the next update.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      r_data      <= '0;
      r_dataValid <= 1'b0;
      r_chIndex   <= '0;
      r_frameDone <= 1'b0;
      r_addr      <= '0;
      r_err       <= 1'b0;
      r_frameCnt  <= '0;
    end else begin
      r_dataValid <= w_dataEvt;
      r_frameDone <= w_lastEvt;
      if (w_dataEvt) begin
        r_data    <= SAMPLE;
        r_chIndex <= r_idx;
      end
      if (w_lastEvt) begin
        r_addr     <= r_addrShift;
        r_err      <= r_errShadow;
        r_frameCnt <= r_frameCnt + 16'd1;
      end
    end
  end

  assign DATA       = r_data;
  assign DATA_VALID = r_dataValid;
  assign CH_INDEX   = r_chIndex;
  assign FRAME_DONE = r_frameDone;
  assign ADDR       = r_addr;
  assign ERR_BIT    = r_err;
  assign FRAME_CNT  = r_frameCnt;

`ifdef APV_SYNC_MON_EN
  logic w_syncPulse;
  logic w_header;

  assign w_syncPulse = SAMPLE_VALID && (r_state == ST_HDR) && !w_high && (r_run == 2'd1);
  assign w_header    = SAMPLE_VALID && (r_state == ST_HDR) && w_high && (r_run == HDR_LAST);

  apv_sync_monitor #(
    .SYNC_PERIOD(SYNC_PERIOD)
  ) u_syncMon (
    .i_clk      (CLK),
    .i_rstb     (RSTb),
    .i_valid    (SAMPLE_VALID),
    .i_syncPulse(w_syncPulse),
    .i_header   (w_header),
    .o_synced   (SYNCED)
  );
`else
  logic w_unusedSyncPeriod;
  assign w_unusedSyncPeriod = ^SYNC_PERIOD;
  assign SYNCED = 1'b0;
`endif

endmodule

// File: tb/tb_apv_frame_decoder.sv
// ---------------------------------------------------------------------------
// tb_apv_frame_decoder
// Self-checking bench for apv_frame_decoder: directed vector table for a
// reference frame, hand-written multi-cycle sequences and a randomized run
// against a stream-level reference model. SYNCED expectations follow
// whether APV_SYNC_MON_EN is defined.
// ---------------------------------------------------------------------------
module tb_apv_frame_decoder;

  localparam logic [11:0] HI     = 12'hB00;
  localparam logic [11:0] LO     = 12'h200;
  localparam int          PERIOD = 35;
`ifdef APV_SYNC_MON_EN
  localparam bit SYNC_EN = 1'b1;
`else
  localparam bit SYNC_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RSTb = 1'b1;
  logic [11:0] SAMPLE = '0;
  logic        SAMPLE_VALID = 1'b0;
  logic [11:0] DATA;
  logic        DATA_VALID;
  logic [6:0]  CH_INDEX;
  logic        FRAME_DONE;
  logic [7:0]  ADDR;
  logic        ERR_BIT;
  logic [15:0] FRAME_CNT;
  logic        SYNCED;

  apv_frame_decoder #(
    .THRESHOLD  (12'h680),
    .SYNC_PERIOD(PERIOD)
  ) dut (
    .CLK         (CLK),
    .RSTb        (RSTb),
    .SAMPLE      (SAMPLE),
    .SAMPLE_VALID(SAMPLE_VALID),
    .DATA        (DATA),
    .DATA_VALID  (DATA_VALID),
    .CH_INDEX    (CH_INDEX),
    .FRAME_DONE  (FRAME_DONE),
    .ADDR        (ADDR),
    .ERR_BIT     (ERR_BIT),
    .FRAME_CNT   (FRAME_CNT),
    .SYNCED      (SYNCED)
  );

  always #5 CLK = ~CLK;

  int nChecks = 0;
  int nPass   = 0;
  int dvCount = 0;
  int doneCount = 0;

  // Reference model: works on the stream of valid samples by position,
  // using absolute sample numbers for sync spacing.
  bit          mInFrame;
  int          mPos;
  int          mRun;
  logic [7:0]  mAddrBits;
  logic        mErrBit;
  longint      mValidNum = 0;
  longint      mLastSyncHigh;
  bit          mArmed;
  bit          mPrevMatch;
  bit          mSynced;
  logic [11:0] eData;
  logic [6:0]  eIdx;
  logic        eDv;
  logic        eDone;
  logic [7:0]  eAddr;
  logic        eErr;
  logic [15:0] eCnt;

  typedef struct {
    logic [11:0] sample;
    logic        expDv;
    logic [11:0] expData;
    logic [6:0]  expIdx;
    logic        expDone;
  } vec_t;

  vec_t vecs[140];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic modelReset();
    mInFrame = 0; mPos = 0; mRun = 0; mAddrBits = '0; mErrBit = 0;
    mArmed = 0; mPrevMatch = 0; mSynced = 0; mLastSyncHigh = 0;
    eData = '0; eIdx = '0; eDv = 0; eDone = 0; eAddr = '0; eErr = 0; eCnt = '0;
  endtask

  task automatic syncSeen(input longint highNum);
    longint spacing;
    if (mArmed) begin
      spacing = highNum - mLastSyncHigh;
      if (spacing == PERIOD) begin
        if (mPrevMatch) mSynced = 1;
        mPrevMatch = 1;
      end else begin
        mPrevMatch = 0;
        mSynced = 0;
      end
    end else begin
      mPrevMatch = 0;
    end
    mLastSyncHigh = highNum;
    mArmed = 1;
  endtask

  task automatic modelStep(input logic [11:0] s, input logic v);
    bit high;
    eDv = 0;
    eDone = 0;
    if (v) begin
      high = (s > 12'h680);
      if (mInFrame) begin
        if (mPos < 8) mAddrBits[7 - mPos] = high;
        else if (mPos == 8) mErrBit = high;
        else begin
          eData = s;
          eIdx = 7'(mPos - 9);
          eDv = 1;
          if (mPos - 9 == 127) begin
            eDone = 1;
            eAddr = mAddrBits;
            eErr = mErrBit;
            eCnt = eCnt + 16'd1;
            mInFrame = 0;
          end
        end
        mPos++;
      end else if (high) begin
        mRun++;
        if (mRun == 3) begin
          mInFrame = 1;
          mPos = 0;
          mRun = 0;
          mArmed = 0;
        end
      end else begin
        if (mRun == 1) syncSeen(mValidNum - 1);
        mRun = 0;
      end
      mValidNum++;
    end
  endtask

  task automatic checkOutput();
    check("DATA_VALID", DATA_VALID, eDv);
    check("FRAME_DONE", FRAME_DONE, eDone);
    check("DATA", DATA, eData);
    check("CH_INDEX", CH_INDEX, eIdx);
    check("ADDR", ADDR, eAddr);
    check("ERR_BIT", ERR_BIT, eErr);
    check("FRAME_CNT", FRAME_CNT, eCnt);
    check("SYNCED", SYNCED, SYNC_EN ? mSynced : 1'b0);
  endtask

  task automatic applyStimulus(input logic [11:0] s, input logic v);
    SAMPLE = s;
    SAMPLE_VALID = v;
    @(posedge CLK);
    #1;
    modelStep(s, v);
    if (DATA_VALID === 1'b1) dvCount++;
    if (FRAME_DONE === 1'b1) doneCount++;
    checkOutput();
  endtask

  task automatic doReset();
    SAMPLE_VALID = 1'b0;
    SAMPLE = '0;
    RSTb = 1'b0;
    #1;
    check("rst DATA", DATA, 0);
    check("rst CH_INDEX", CH_INDEX, 0);
    check("rst DATA_VALID", DATA_VALID, 0);
    check("rst FRAME_DONE", FRAME_DONE, 0);
    check("rst ADDR", ADDR, 0);
    check("rst ERR_BIT", ERR_BIT, 0);
    check("rst FRAME_CNT", FRAME_CNT, 0);
    check("rst SYNCED", SYNCED, 0);
    modelReset();
    @(posedge CLK);
    #1;
    RSTb = 1'b1;
  endtask

  task automatic sendValid(input logic [11:0] s, input bit gaps);
    applyStimulus(s, 1'b1);
    if (gaps) applyStimulus(12'($urandom), 1'b0);
  endtask

  function automatic logic [11:0] dataWord(input int i, input int pattern);
    if (pattern == 0) return 12'(i);
    if (pattern == 1) return ((i % 8) < 4) ? 12'hFFF : 12'(i * 29);
    return 12'($urandom);
  endfunction

  task automatic sendFrame(input logic [7:0] addr, input logic err, input int nData,
                           input int pattern, input bit gaps);
    for (int i = 0; i < 3; i++) sendValid(HI, gaps);
    for (int b = 7; b >= 0; b--) sendValid(addr[b] ? HI : LO, gaps);
    sendValid(err ? HI : LO, gaps);
    for (int i = 0; i < nData; i++) sendValid(dataWord(i, pattern), gaps);
  endtask

  task automatic syncPulses(input int n, input int spacing);
    for (int p = 0; p < n; p++) begin
      applyStimulus(HI, 1'b1);
      for (int k = 1; k < spacing; k++) applyStimulus(LO, 1'b1);
    end
  endtask

  task automatic randomChunk(input int len);
    logic [11:0] s;
    for (int i = 0; i < len; i++) begin
      case ($urandom_range(0, 4))
        0: s = 12'h680;
        1: s = 12'h681;
        2: s = 12'($urandom_range(12'h681, 12'hFFF));
        3: s = 12'($urandom_range(0, 12'h680));
        default: s = 12'($urandom);
      endcase
      applyStimulus(s, ($urandom_range(0, 3) != 0));
    end
  endtask

  initial begin
    int dv0;
    int done0;
    logic [7:0] rAddr;

    #2;
    doReset();

    // Sync pulse train: lock on the third pulse, no data produced
    syncPulses(2, PERIOD);
    check("sync after 2 pulses", SYNCED, 0);
    syncPulses(1, PERIOD);
    check("sync at 3rd pulse", SYNCED, SYNC_EN);
    check("sync train no data", dvCount, 0);
    syncPulses(1, PERIOD - 1);
    check("sync held at 4th pulse", SYNCED, SYNC_EN);
    syncPulses(1, PERIOD);
    check("sync lost on spacing 34", SYNCED, 0);

    // Two highs then low is a glitch, not a header
    dv0 = dvCount;
    applyStimulus(HI, 1'b1);
    applyStimulus(HI, 1'b1);
    applyStimulus(LO, 1'b1);
    for (int i = 0; i < 140; i++) applyStimulus(LO, 1'b1);
    check("glitch no data", dvCount, dv0);

    // Reference frame from the vector table
    doReset();
    for (int i = 0; i < 140; i++) begin
      vecs[i].expDv = 0; vecs[i].expData = '0; vecs[i].expIdx = '0; vecs[i].expDone = 0;
      if (i < 3) vecs[i].sample = HI;
      else if (i < 11) vecs[i].sample = ((i - 3) % 2 == 1) ? HI : LO;
      else if (i == 11) vecs[i].sample = LO;
      else begin
        vecs[i].sample  = 12'(i - 12);
        vecs[i].expDv   = 1;
        vecs[i].expData = 12'(i - 12);
        vecs[i].expIdx  = 7'(i - 12);
        vecs[i].expDone = (i == 139);
      end
    end
    for (int i = 0; i < 140; i++) begin
      applyStimulus(vecs[i].sample, 1'b1);
      check("vec DATA_VALID", DATA_VALID, vecs[i].expDv);
      check("vec FRAME_DONE", FRAME_DONE, vecs[i].expDone);
      if (vecs[i].expDv) begin
        check("vec DATA", DATA, vecs[i].expData);
        check("vec CH_INDEX", CH_INDEX, vecs[i].expIdx);
      end
    end
    check("frame1 ADDR", ADDR, 8'h55);
    check("frame1 ERR_BIT", ERR_BIT, 0);
    check("frame1 FRAME_CNT", FRAME_CNT, 1);

    // Three back-to-back frames with 0xFFF runs in the payload
    doReset();
    dv0 = dvCount;
    done0 = doneCount;
    sendFrame(8'hA3, 1'b1, 128, 1, 1'b0);
    sendFrame(8'h3C, 1'b0, 128, 1, 1'b0);
    sendFrame(8'hC5, 1'b1, 128, 1, 1'b0);
    check("b2b FRAME_CNT", FRAME_CNT, 3);
    check("b2b ADDR", ADDR, 8'hC5);
    check("b2b ERR_BIT", ERR_BIT, 1);
    check("b2b data strobes", dvCount - dv0, 384);
    check("b2b done pulses", doneCount - done0, 3);

    // Reset in the middle of a frame
    doReset();
    sendFrame(8'h77, 1'b1, 61, 0, 1'b0);
    check("pre-reset CH_INDEX", CH_INDEX, 60);
    done0 = doneCount;
    doReset();
    check("mid-reset no done", doneCount, done0);
    sendFrame(8'h9A, 1'b0, 128, 2, 1'b0);
    check("post-reset FRAME_CNT", FRAME_CNT, 1);
    check("post-reset ADDR", ADDR, 8'h9A);
    check("post-reset ERR_BIT", ERR_BIT, 0);

    // Valid toggling through a frame
    doReset();
    dv0 = dvCount;
    sendFrame(8'h55, 1'b0, 128, 0, 1'b1);
    check("gap FRAME_CNT", FRAME_CNT, 1);
    check("gap ADDR", ADDR, 8'h55);
    check("gap data strobes", dvCount - dv0, 128);

    // Randomized mix against the reference model
    doReset();
    for (int seg = 0; seg < 60; seg++) begin
      case ($urandom_range(0, 5))
        0, 1: randomChunk(int'($urandom_range(10, 40)));
        2: syncPulses(int'($urandom_range(1, 4)), int'($urandom_range(33, 37)));
        3: begin
          rAddr = 8'($urandom);
          sendFrame(rAddr, 1'($urandom), 128, 2, 1'($urandom));
        end
        4: if ($urandom_range(0, 3) == 0) doReset();
        default: begin
          for (int k = 0; k < int'($urandom_range(1, 2)); k++) applyStimulus(HI, 1'b1);
          applyStimulus(LO, 1'b1);
        end
      endcase
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/apv_frame_decoder.md
APV_FRAME_DECODER -- requirements
Module: apv_frame_decoder

Interface
REQ-001 SHALL have parameter THRESHOLD, default 12'h680: digital-one threshold, compared unsigned; a sample is "high" when SAMPLE > THRESHOLD.
REQ-002 SHALL have parameter SYNC_PERIOD, default 35: sync-pulse spacing in samples.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port RSTb, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port SAMPLE, input, 12 bits: deserialized ADC word for one APV channel.
REQ-006 SHALL have port SAMPLE_VALID, input, 1 bit: SAMPLE is qualified; gaps are allowed.
REQ-007 SHALL have port DATA, output, 12 bits: analog sample payload.
REQ-008 SHALL have port DATA_VALID, output, 1 bit: one-cycle strobe qualifying DATA and CH_INDEX.
REQ-009 SHALL have port CH_INDEX, output, 7 bits: strip index 0..127 of DATA.
REQ-010 SHALL have port FRAME_DONE, output, 1 bit: one-cycle pulse at the end of a frame.
REQ-011 SHALL have port ADDR, output, 8 bits: pipeline address of the last frame, MSB first.
REQ-012 SHALL have port ERR_BIT, output, 1 bit: raw error bit of the last frame.
REQ-013 SHALL have port FRAME_CNT, output, 16 bits: count of completed frames; wraps 0xFFFF->0.
REQ-014 SHALL have port SYNCED, output, 1 bit: sync-pulse train locked.

Function
REQ-015 SHALL update state only on cycles with SAMPLE_VALID=1; on other cycles all state holds and strobes are 0.
REQ-016 SHALL implement states IDLE, HDR, ADDR, ERRB, DATA.
REQ-017 IDLE: a high sample SHALL enter HDR with run=1.
REQ-018 HDR: a high sample SHALL increment run; at run=3 it SHALL enter ADDR, so the 4th sample is address bit 7.
REQ-019 HDR: a low sample with run=1 SHALL be classified as a sync pulse and return to IDLE.
REQ-020 HDR: a low sample with run=2 SHALL be discarded as a glitch and return to IDLE.
REQ-021 ADDR SHALL shift in 8 samples MSB first (high=1), then enter ERRB.
REQ-022 ERRB SHALL capture one bit, then enter DATA with index 0.
REQ-023 DATA SHALL pass every sample unthresholded: DATA=SAMPLE, CH_INDEX=index, DATA_VALID=1, one cycle after the qualifying clock edge.
REQ-024 After index 127 the decoder SHALL return to IDLE.
REQ-025 On index 127, FRAME_DONE SHALL pulse in the same cycle as that DATA_VALID; ADDR/ERR_BIT SHALL update in that cycle; FRAME_CNT SHALL increment in that cycle.
REQ-026 High samples in DATA SHALL NOT be treated as headers; consecutive frames SHALL each need a fresh 3-high header from IDLE.
REQ-027 ADDR and ERR_BIT SHALL hold between frames and are never changed by partial frames.

Reset
REQ-028 RSTb=0 SHALL force IDLE, run=0, index=0, DATA=0, CH_INDEX=0, DATA_VALID=0, FRAME_DONE=0, ADDR=0, ERR_BIT=0, FRAME_CNT=0, SYNCED=0 immediately.
REQ-029 Reset mid-frame SHALL discard the partial frame, with no FRAME_DONE; decoding resumes at the next header after release.

Configuration
REQ-030 Macro APV_SYNC_MON_EN SHALL compile in the sync monitor; without the macro, SYNCED is tied 0 and no spacing counter exists.
REQ-031 Sync monitor spacing SHALL be the number of valid samples from one sync pulse's high sample to the next.
REQ-032 Two consecutive spacings equal to SYNC_PERIOD SHALL set SYNCED=1.
REQ-033 Any spacing not equal to SYNC_PERIOD SHALL clear SYNCED.
REQ-034 A header SHALL freeze the spacing counter and leave SYNCED unchanged; the first sync pulse after FRAME_DONE re-arms the counter without a check.
REQ-035 The spacing counter SHALL saturate at 63; saturation counts as a mismatch.

Structure
REQ-036 Shared package apv_pkg SHALL hold the state enum, APV_FRAME_LEN=128, APV_ADDR_BITS=8 and APV_HDR_LEN=3.
REQ-037 Sub-module apv_sync_monitor SHALL contain the sync monitor, instantiated only under APV_SYNC_MON_EN.

Verification
REQ-038 Continuous sync train, high=0xB00 and low=0x200 every 35 samples -> SYNCED=1 at the 3rd pulse; no DATA_VALID.
REQ-039 Header 111, address 01010101, error 0, then samples 0x000..0x07F -> 128 DATA_VALID with DATA=CH_INDEX; FRAME_DONE with ADDR=0x55, ERR_BIT=0, FRAME_CNT=1.
REQ-040 Three back-to-back frames (APV_MODE=0 style) -> FRAME_CNT=3; data sample 0xFFF is not taken as a header.
REQ-041 Samples B00,B00,200 -> glitch, stays IDLE; a sync spacing of 34 -> SYNCED falls to 0.
REQ-042 RSTb low at CH_INDEX=60 -> outputs are zero; the next full frame decodes correctly with FRAME_CNT=1.
REQ-043 SAMPLE_VALID toggling 1/0 through a frame -> results identical to the gap-free case, with DATA_VALID only after valid cycles.
